// File: rtl/usb_bus_arb_pkg.sv
// rtl/usb_bus_arb_pkg.sv - shared types and bounds for the USB core bus arbiter
//
// Purpose: FSM state encoding, parameter bounds and common widths used by
//          usb_bus_arb and usb_rr_pick.
// Contents:
//   arb_state_t          IDLE / ACCESS / RELEASE state encoding
//   N_MIN, N_MAX         legal range of the requester count
//   TIMEOUT_MIN/MAX      legal range of the ack timeout
//   IDX_W, CNT_W, DATA_W requester index, timeout counter and bus data widths
package usb_bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    localparam int N_MIN       = 2;
    localparam int N_MAX       = 4;
    localparam int TIMEOUT_MIN = 1;
    localparam int TIMEOUT_MAX = 255;

    // Index width covers N_MAX requesters; counter width covers TIMEOUT_MAX.
    localparam int IDX_W  = 2;
    localparam int CNT_W  = 8;
    localparam int DATA_W = 16;

endpackage

// File: rtl/usb_rr_pick.sv
// rtl/usb_rr_pick.sv - combinational round-robin requester selector
//
// Purpose: choose the first active requester at or after last+1, wrapping
//          modulo N.
// Ports:
//   req    in   N      request vector
//   last   in   IDX_W  index of the last granted requester
//   grant  out  IDX_W  selected requester index (0 when valid is low)
//   valid  out  1      at least one request is active
module usb_rr_pick
    import usb_bus_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    // Distance k of requester i from last+1 is (i + N - 1 - last) mod N;
    // the active requester with the smallest distance wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!valid && req[i] && (((i + N - 1 - int'(last)) % N) == k)) begin
                    valid = 1'b1;
                    grant = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/usb_bus_arb.sv
// rtl/usb_bus_arb.sv - round-robin arbiter for the USB core register/EP-status bus
//
// Purpose: share one registered master port of the USB core bus between N
//          requesters, with an ack timeout and a mandatory idle cycle between
//          bus cycles.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   m_req/m_we   in  N  per-requester request and write flag
//   m_addr/m_wdata in 16*N  per-requester address and write data (16 bits each)
//   m_ack/m_err  out N  one-cycle completion / timeout pulse to the granted requester
//   m_rdata      out 16 read data, valid in the m_ack cycle
//   bus_addr/bus_din/bus_we/bus_cyc  out  registered master side of the core bus
//   bus_dout/bus_ack     in  slave side of the core bus
module usb_bus_arb
    import usb_bus_arb_pkg::*;
#(
    parameter int N       = 2,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      m_req,
    input  logic [N-1:0]      m_we,
    input  logic [16*N-1:0]   m_addr,
    input  logic [16*N-1:0]   m_wdata,
    output logic [N-1:0]      m_ack,
    output logic [N-1:0]      m_err,
    output logic [15:0]       m_rdata,
    output logic [15:0]       bus_addr,
    output logic [15:0]       bus_din,
    output logic              bus_we,
    output logic              bus_cyc,
    input  logic [15:0]       bus_dout,
    input  logic              bus_ack
);

    if (N < N_MIN || N > N_MAX) begin : g_bad_n
        $error("usb_bus_arb: N out of range");
    end
    if (TIMEOUT < TIMEOUT_MIN || TIMEOUT > TIMEOUT_MAX) begin : g_bad_timeout
        $error("usb_bus_arb: TIMEOUT out of range");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]  bus_din_q, bus_din_d;
    logic [DATA_W-1:0]  m_rdata_q, m_rdata_d;
    logic               bus_we_q, bus_we_d;
    logic               bus_cyc_q, bus_cyc_d;
    logic [N-1:0]       m_ack_q, m_ack_d;
    logic [N-1:0]       m_err_q, m_err_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [DATA_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_we;
    logic [N-1:0]       gnt_oh;
    logic               timeout_hit;

    usb_rr_pick #(
        .N (N)
    ) u_rr_pick (
        .req   (m_req),
        .last  (last_q),
        .grant (pick_idx),
        .valid (pick_valid)
    );

    // Requester fields for the candidate chosen this cycle.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_addr  = m_addr[16*i +: 16];
                sel_wdata = m_wdata[16*i +: 16];
                sel_we    = m_we[i];
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        for (int i = 0; i < N; i++) begin
            gnt_oh[i] = (gnt_q == IDX_W'(i));
        end
    end

    assign timeout_hit = (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (bus_ack || timeout_hit) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values. Ack is tested before the timeout so
    // that a late ack on the final allowed cycle still completes normally.
    always_comb begin
        last_d     = last_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        bus_addr_d = bus_addr_q;
        bus_din_d  = bus_din_q;
        bus_we_d   = bus_we_q;
        bus_cyc_d  = bus_cyc_q;
        m_rdata_d  = m_rdata_q;
        m_ack_d    = '0;
        m_err_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    last_d     = pick_idx;
                    gnt_d      = pick_idx;
                    cnt_d      = '0;
                    bus_addr_d = sel_addr;
                    bus_din_d  = sel_wdata;
                    bus_we_d   = sel_we;
                    bus_cyc_d  = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (bus_ack) begin
                    if (!bus_we_q) begin
                        m_rdata_d = bus_dout;
                    end
                    m_ack_d   = gnt_oh;
                    bus_cyc_d = 1'b0;
                end else if (timeout_hit) begin
                    m_err_d   = gnt_oh;
                    bus_cyc_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                bus_cyc_d = 1'b0;
            end
        endcase
    end

    // Output registers, pointer and timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= IDX_W'(N - 1);
            gnt_q      <= '0;
            cnt_q      <= '0;
            bus_addr_q <= 16'h0000;
            bus_din_q  <= 16'h0000;
            bus_we_q   <= 1'b0;
            bus_cyc_q  <= 1'b0;
            m_rdata_q  <= 16'h0000;
            m_ack_q    <= '0;
            m_err_q    <= '0;
        end else begin
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            bus_addr_q <= bus_addr_d;
            bus_din_q  <= bus_din_d;
            bus_we_q   <= bus_we_d;
            bus_cyc_q  <= bus_cyc_d;
            m_rdata_q  <= m_rdata_d;
            m_ack_q    <= m_ack_d;
            m_err_q    <= m_err_d;
        end
    end

    assign bus_addr = bus_addr_q;
    assign bus_din  = bus_din_q;
    assign bus_we   = bus_we_q;
    assign bus_cyc  = bus_cyc_q;
    assign m_rdata  = m_rdata_q;
    assign m_ack    = m_ack_q;
    assign m_err    = m_err_q;

endmodule

// File: doc/usb_bus_arb.md
USB_BUS_ARB -- requirements
Module: usb_bus_arb

Interface
REQ-001 Parameter N, default 2: number of requesters sharing the USB core register/EP-status bus; legal range 2..4.
REQ-002 Parameter TIMEOUT, default 15: maximum cycles bus_cyc stays high waiting for bus_ack; legal range 1..255.
REQ-003 clk  input  1  clock for all logic.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 m_req  input  N  per-requester access request; the requester holds it high until its m_ack or m_err pulse.
REQ-006 m_we  input  N  per-requester write flag; 1 = write.
REQ-007 m_addr  input  16*N  per-requester address; requester i uses bits [16i+15:16i].
REQ-008 m_wdata  input  16*N  per-requester write data, packed like m_addr.
REQ-009 m_ack  output  N  one-cycle completion pulse to the granted requester.
REQ-010 m_err  output  N  one-cycle timeout pulse to the granted requester.
REQ-011 m_rdata  output  16  read data, shared by all requesters; valid in the m_ack cycle.
REQ-012 bus_addr, bus_din, bus_we  output  16, 16, 1  registered master side of the USB core bus.
REQ-013 bus_cyc  output  1  registered bus cycle strobe.
REQ-014 bus_dout, bus_ack  input  16, 1  slave side of the USB core bus.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and RELEASE.
REQ-016 In IDLE with any m_req high, the arbiter SHALL pick the next requester round-robin, starting at last-granted+1 and wrapping modulo N; it SHALL latch that requester's addr, wdata and we onto bus_addr, bus_din and bus_we, set bus_cyc=1 and go to ACCESS on the same edge.
REQ-017 The bus_* outputs SHALL stay constant for the whole ACCESS state.
REQ-018 In ACCESS with bus_ack=1, on the next edge the arbiter SHALL: capture bus_dout into m_rdata (reads only; writes leave it unchanged), pulse m_ack[g] for one cycle, clear bus_cyc, and go to RELEASE.
REQ-019 Minimum latency, m_req high in IDLE to m_ack, SHALL be 2 cycles when the core acks in the first ACCESS cycle.
REQ-020 A timeout counter SHALL clear on ACCESS entry and increment each ACCESS cycle without bus_ack.
REQ-021 When the counter equals TIMEOUT-1 and bus_ack=0, the arbiter SHALL pulse m_err[g], leave m_rdata unchanged, clear bus_cyc and go to RELEASE.
REQ-022 If bus_ack and the timeout condition coincide, the ack SHALL win.
REQ-023 RELEASE SHALL last exactly one cycle with bus_cyc=0, then return to IDLE; this guarantees the core sees cyc drop between accesses.
REQ-024 If m_req[g] drops during ACCESS, the bus cycle SHALL still complete and m_ack/m_err SHALL still pulse.
REQ-025 m_req of a requester that is not granted SHALL be ignored until the next IDLE arbitration.
REQ-026 At most one bit of m_ack|m_err SHALL be high in any cycle.
REQ-027 The last-granted pointer SHALL update on IDLE->ACCESS only.
REQ-028 With all requesters continuously requesting, each SHALL be served once every N accesses.

Reset
REQ-029 On rst, state SHALL be IDLE, and bus_cyc, bus_we, m_ack, m_err and the counter SHALL be 0.
REQ-030 On rst, bus_addr, bus_din and m_rdata SHALL be 16'h0000.
REQ-031 On rst, the last-granted pointer SHALL be N-1, so requester 0 wins first.
REQ-032 A reset asserted mid-ACCESS SHALL drop bus_cyc immediately (asynchronously) and SHALL produce no m_ack or m_err pulse.

Structure
REQ-033 The FSM state encoding and the N and TIMEOUT bounds SHALL live in the shared USB package.
REQ-034 The round-robin selector SHALL be one sub-module, usb_rr_pick: inputs request vector and last pointer; outputs grant index and valid; purely combinational.
REQ-035 The top level SHALL contain the FSM, output registers and timeout counter.

Verification
REQ-036 Read: m_req[0]=1, m_we[0]=0, m_addr=16'h3800; core acks on the 1st ACCESS cycle with 16'hA55A -> bus_cyc high 1 cycle, m_ack[0] at cycle 2, m_rdata=16'hA55A.
REQ-037 Write: m_req[1]=1, m_we[1]=1, m_addr=16'h3000, m_wdata=16'h8000 -> bus_din=16'h8000 and bus_we=1 while cyc is high; m_ack[1] pulses; m_rdata unchanged.
REQ-038 Round-robin: both requesters request continuously, immediate ack -> grant order 0,1,0,1; bus_cyc low exactly 1 RELEASE cycle plus 1 IDLE cycle between accesses.
REQ-039 Timeout: TIMEOUT=4, core never acks -> bus_cyc high 4 cycles, then m_err[g]=1 for one cycle, no m_ack.
REQ-040 Coincidence: TIMEOUT=4, ack on the 4th ACCESS cycle -> m_ack pulses, no m_err.
REQ-041 Reset mid-ACCESS: assert rst during ACCESS -> bus_cyc=0 asynchronously, no pulses; after release, requester 0 is granted first.
